ahb_gpio_irq_port: RTL and testbench

Second-generation AHB-Lite GPIO port for the SoC peripheral subsystem.
- Pin width is a parameter.
- Every input passes through a 2-flop synchroniser and a programmable-length glitch filter.
- Interrupts are per pin and can be level (high/low) or edge (rising/falling/both), with sticky raw status, masked status and write-1-to-clear.
- Atomic set/clear aliases for the output register remove read-modify-write races between software threads.

---
 rtl/ahb_gpio_irq_port.sv | 231 +++++++++++++++++++++++
 tb/tb_ahb_gpio_irq_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_irq_port.sv
`default_nettype none
// ============================================================================
// Module   : ahb_gpio_irq_port
// Brief    : AHB-Lite GPIO port with synchronised, glitch-filtered inputs,
//            per-pin level/edge interrupts and atomic output set/clear.
// Revision : 2.0
// ============================================================================
module ahb_gpio_irq_port #(
    parameter int SZ = 8,
    parameter int FW = 4
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          IRQ,
    input  logic [SZ-1:0] GPIO_DIN,
    output logic [SZ-1:0] GPIO_OUT,
    output logic [SZ-1:0] GPIO_PU,
    output logic [SZ-1:0] GPIO_PD,
    output logic [SZ-1:0] GPIO_OE
);

    localparam logic [7:0] c_off_out  = 8'h00;
    localparam logic [7:0] c_off_data = 8'h04;
    localparam logic [7:0] c_off_pu   = 8'h08;
    localparam logic [7:0] c_off_pd   = 8'h0C;
    localparam logic [7:0] c_off_oe   = 8'h10;
    localparam logic [7:0] c_off_im   = 8'h14;
    localparam logic [7:0] c_off_ris  = 8'h18;
    localparam logic [7:0] c_off_mis  = 8'h1C;
    localparam logic [7:0] c_off_icr  = 8'h20;
    localparam logic [7:0] c_off_is   = 8'h24;
    localparam logic [7:0] c_off_iev  = 8'h28;
    localparam logic [7:0] c_off_ibe  = 8'h2C;
    localparam logic [7:0] c_off_oset = 8'h30;
    localparam logic [7:0] c_off_oclr = 8'h34;
    localparam logic [7:0] c_off_flt  = 8'h38;
    localparam logic [31:0] c_bad_rd  = 32'hDEAD_BEEF;

    // ------------------------------------------------------------------
    // Bus address/data phase tracking
    // ------------------------------------------------------------------
    logic          w_addr_phase;
    logic [7:0]    r_addr;
    logic          r_wr_pend;
    logic [SZ-1:0] w_wd;
    logic [FW-1:0] w_wd_flt;

    assign w_addr_phase = HSEL & HREADY & HTRANS[1];
    assign w_wd         = HWDATA[SZ-1:0];
    assign w_wd_flt     = HWDATA[FW-1:0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_addr    <= 8'h00;
            r_wr_pend <= 1'b0;
        end else begin
            if (w_addr_phase) begin
                r_addr <= HADDR[7:0];
            end
            r_wr_pend <= w_addr_phase & HWRITE;
        end
    end

    logic w_we_out, w_we_pu, w_we_pd, w_we_oe, w_we_im, w_we_icr;
    logic w_we_is, w_we_iev, w_we_ibe, w_we_oset, w_we_oclr, w_we_flt;

    assign w_we_out  = r_wr_pend && (r_addr == c_off_out);
    assign w_we_pu   = r_wr_pend && (r_addr == c_off_pu);
    assign w_we_pd   = r_wr_pend && (r_addr == c_off_pd);
    assign w_we_oe   = r_wr_pend && (r_addr == c_off_oe);
    assign w_we_im   = r_wr_pend && (r_addr == c_off_im);
    assign w_we_icr  = r_wr_pend && (r_addr == c_off_icr);
    assign w_we_is   = r_wr_pend && (r_addr == c_off_is);
    assign w_we_iev  = r_wr_pend && (r_addr == c_off_iev);
    assign w_we_ibe  = r_wr_pend && (r_addr == c_off_ibe);
    assign w_we_oset = r_wr_pend && (r_addr == c_off_oset);
    assign w_we_oclr = r_wr_pend && (r_addr == c_off_oclr);
    assign w_we_flt  = r_wr_pend && (r_addr == c_off_flt);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [SZ-1:0] r_out, r_pu, r_pd, r_oe, r_im, r_is, r_iev, r_ibe;
    logic [FW-1:0] r_flt;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_out <= '0;
            r_pu  <= '0;
            r_pd  <= '0;
            r_oe  <= '0;
            r_im  <= '0;
            r_is  <= '0;
            r_iev <= '0;
            r_ibe <= '0;
            r_flt <= '0;
        end else begin
            // Only one bus write lands per cycle, so these never compete.
            if (w_we_out) begin
                r_out <= w_wd;
            end else if (w_we_oset) begin
                r_out <= r_out | w_wd;
            end else if (w_we_oclr) begin
                r_out <= r_out & ~w_wd;
            end
            if (w_we_pu)  r_pu  <= w_wd;
            if (w_we_pd)  r_pd  <= w_wd;
            if (w_we_oe)  r_oe  <= w_wd;
            if (w_we_im)  r_im  <= w_wd;
            if (w_we_is)  r_is  <= w_wd;
            if (w_we_iev) r_iev <= w_wd;
            if (w_we_ibe) r_ibe <= w_wd;
            if (w_we_flt) r_flt <= w_wd_flt;
        end
    end

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser, glitch filter, edge history
    // ------------------------------------------------------------------
    logic [SZ-1:0] r_s1, r_s2, r_data, r_prev;
    logic [FW-1:0] r_cnt [SZ];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_data <= '0;
            r_prev <= '0;
            for (int i = 0; i < SZ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= GPIO_DIN;
            r_s2   <= r_s1;
            r_prev <= r_data;
            for (int i = 0; i < SZ; i++) begin
                if (r_flt == '0) begin
                    r_data[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else if (r_s2[i] == r_data[i]) begin
                    r_cnt[i]  <= '0;
                end else if (r_cnt[i] == r_flt) begin
                    // s2 has disagreed with DATA for N consecutive cycles
                    r_data[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i]  <= r_cnt[i] + 1'b1;
                end
                if (w_we_flt) begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt status
    // ------------------------------------------------------------------
    logic [SZ-1:0] w_rise, w_fall, w_ev, w_icr, w_ris, w_mis;
    logic [SZ-1:0] r_ris_edge;

    assign w_rise = r_data & ~r_prev;
    assign w_fall = ~r_data & r_prev;
    assign w_ev   = (r_ibe & (w_rise | w_fall))
                  | (~r_ibe & ((r_iev & w_rise) | (~r_iev & w_fall)));
    assign w_icr  = w_we_icr ? w_wd : '0;

    // Level-mode pins hold no sticky state; set beats a simultaneous clear.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ris_edge <= '0;
        end else begin
            r_ris_edge <= r_is & ((r_ris_edge & ~w_icr) | w_ev);
        end
    end

    assign w_ris = (r_is & r_ris_edge) | (~r_is & ~(r_data ^ r_iev));
    assign w_mis = w_ris & r_im;
    assign IRQ   = |w_mis;

    // ------------------------------------------------------------------
    // Read mux and constant responses
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (r_addr)
            c_off_out:  w_rdata[SZ-1:0] = r_out;
            c_off_data: w_rdata[SZ-1:0] = r_data;
            c_off_pu:   w_rdata[SZ-1:0] = r_pu;
            c_off_pd:   w_rdata[SZ-1:0] = r_pd;
            c_off_oe:   w_rdata[SZ-1:0] = r_oe;
            c_off_im:   w_rdata[SZ-1:0] = r_im;
            c_off_ris:  w_rdata[SZ-1:0] = w_ris;
            c_off_mis:  w_rdata[SZ-1:0] = w_mis;
            c_off_icr:  w_rdata = '0;
            c_off_is:   w_rdata[SZ-1:0] = r_is;
            c_off_iev:  w_rdata[SZ-1:0] = r_iev;
            c_off_ibe:  w_rdata[SZ-1:0] = r_ibe;
            c_off_oset: w_rdata = '0;
            c_off_oclr: w_rdata = '0;
            c_off_flt:  w_rdata[FW-1:0] = r_flt;
            default:    w_rdata = c_bad_rd;
        endcase
    end

    assign HRDATA    = w_rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign GPIO_OUT = r_out;
    assign GPIO_PU  = r_pu;
    assign GPIO_PD  = r_pd;
    assign GPIO_OE  = r_oe;

    logic w_unused;
    assign w_unused = &{1'b0, HSIZE, HADDR[31:8], HWDATA, HTRANS[0]};

endmodule
`default_nettype wire

// File: tb/tb_ahb_gpio_irq_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_gpio_irq_port
// Brief    : Directed, table-driven self-checking bench for ahb_gpio_irq_port.
// Revision : 2.0
// ============================================================================
module tb_ahb_gpio_irq_port;

    localparam int SZ = 8;
    localparam int FW = 4;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = '0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE = 3'b010;
    logic [31:0]   HWDATA = '0;
    logic          HREADY = 1'b1;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          IRQ;
    logic [SZ-1:0] GPIO_DIN = '0;
    logic [SZ-1:0] GPIO_OUT, GPIO_PU, GPIO_PD, GPIO_OE;

    ahb_gpio_irq_port #(.SZ(SZ), .FW(FW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .IRQ(IRQ), .GPIO_DIN(GPIO_DIN),
        .GPIO_OUT(GPIO_OUT), .GPIO_PU(GPIO_PU), .GPIO_PD(GPIO_PD),
        .GPIO_OE(GPIO_OE)
    );

    always #5 HCLK = ~HCLK;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic        do_wr;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [7:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, a}; HWRITE = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); @(negedge HCLK);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, a}; HWRITE = 1'b0;
        @(posedge HCLK); @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        seen;
        int          first;

        vecs[0]  = '{1'b1, 8'h00, 32'hFFFF_FFA5, 8'h00, 32'h0000_00A5};
        vecs[1]  = '{1'b1, 8'h08, 32'h1234_5633, 8'h08, 32'h0000_0033};
        vecs[2]  = '{1'b1, 8'h0C, 32'h0000_000F, 8'h0C, 32'h0000_000F};
        vecs[3]  = '{1'b1, 8'h10, 32'h0000_00C3, 8'h10, 32'h0000_00C3};
        vecs[4]  = '{1'b1, 8'h28, 32'h0000_005A, 8'h28, 32'h0000_005A};
        vecs[5]  = '{1'b1, 8'h2C, 32'h0000_0081, 8'h2C, 32'h0000_0081};
        vecs[6]  = '{1'b1, 8'h38, 32'hFFFF_FFF7, 8'h38, 32'h0000_0007};
        vecs[7]  = '{1'b1, 8'h3C, 32'h0000_1234, 8'h3C, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 8'h30, 32'h0000_000F, 8'h00, 32'h0000_00AF};
        vecs[9]  = '{1'b1, 8'h34, 32'h0000_000F, 8'h00, 32'h0000_00A0};
        vecs[10] = '{1'b0, 8'h00, 32'h0,         8'h30, 32'h0000_0000};
        vecs[11] = '{1'b0, 8'h00, 32'h0,         8'h34, 32'h0000_0000};
        vecs[12] = '{1'b1, 8'h04, 32'h0000_00FF, 8'h04, 32'h0000_0000};
        vecs[13] = '{1'b1, 8'h14, 32'h0000_003C, 8'h14, 32'h0000_003C};
        vecs[14] = '{1'b0, 8'h00, 32'h0,         8'h18, 32'h0000_00A5};
        vecs[15] = '{1'b0, 8'h00, 32'h0,         8'h1C, 32'h0000_0024};
        vecs[16] = '{1'b1, 8'h20, 32'h0000_00FF, 8'h20, 32'h0000_0000};
        vecs[17] = '{1'b0, 8'h00, 32'h0,         8'h18, 32'h0000_00A5};
        vecs[18] = '{1'b1, 8'h01, 32'h0000_00FF, 8'h01, 32'hDEAD_BEEF};
        vecs[19] = '{1'b0, 8'h00, 32'h0,         8'h00, 32'h0000_00A0};
        vecs[20] = '{1'b1, 8'h24, 32'h0000_00FF, 8'h24, 32'h0000_00FF};
        vecs[21] = '{1'b0, 8'h00, 32'h0,         8'h18, 32'h0000_0000};

        // Reset with pads high: registers 0, DATA appears on the third edge.
        GPIO_DIN = 8'hFF;
        do_reset();
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        check("rst_gpio_out", {24'h0, GPIO_OUT}, 32'h0);
        check("rst_const", {30'h0, HREADYOUT, HRESP}, 32'h2);
        rd(8'h04, d); check("din_edge1", d, 32'h0);
        rd(8'h04, d); check("din_edge2", d, 32'h0);
        rd(8'h04, d); check("din_edge3", d, 32'h0000_00FF);
        check("rst_irq_after", {31'h0, IRQ}, 32'h0);

        // Atomic set/clear aliases
        wr(8'h00, 32'h0000_00F0);
        wr(8'h30, 32'h0000_0003);
        wr(8'h34, 32'h0000_0010);
        check("oset_oclr_pad", {24'h0, GPIO_OUT}, 32'h0000_00E3);
        rd(8'h30, d); check("oset_reads0", d, 32'h0);
        rd(8'h3C, d); check("unmapped_3c", d, 32'hDEAD_BEEF);

        // Register map table
        GPIO_DIN = 8'h00;
        do_reset();
        cycles(4);
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].wa, vecs[i].wd);
            rd(vecs[i].ra, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        check("pad_pu", {24'h0, GPIO_PU}, 32'h33);
        check("pad_pd", {24'h0, GPIO_PD}, 32'h0F);
        check("pad_oe", {24'h0, GPIO_OE}, 32'hC3);
        check("pad_out", {24'h0, GPIO_OUT}, 32'hA0);
        check("tbl_irq", {31'h0, IRQ}, 32'h0);

        // Glitch filter, N = 4
        do_reset();
        cycles(4);
        wr(8'h38, 32'h4);
        seen = 1'b0;
        GPIO_DIN[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) GPIO_DIN[0] = 1'b0;
            rd(8'h04, d);
            if (d[0]) seen = 1'b1;
        end
        check("glitch_blocked", {31'h0, seen}, 32'h0);
        first = 0;
        GPIO_DIN[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            rd(8'h04, d);
            if (d[0] && first == 0) first = k;
        end
        GPIO_DIN[0] = 1'b0;
        check("filter_latency", first, 7);

        // Rising-edge interrupt on pin0, W1C, set-beats-clear
        do_reset();
        cycles(4);
        wr(8'h24, 32'h01);
        wr(8'h28, 32'h01);
        wr(8'h14, 32'h01);
        check("edge_irq_idle", {31'h0, IRQ}, 32'h0);
        GPIO_DIN[0] = 1'b1;
        cycles(5);
        check("edge_irq_set", {31'h0, IRQ}, 32'h1);
        rd(8'h1C, d); check("edge_mis", d, 32'h1);
        wr(8'h20, 32'h01);
        check("edge_icr_clear", {31'h0, IRQ}, 32'h0);
        GPIO_DIN[0] = 1'b0;
        cycles(6);
        check("edge_fall_ignored", {31'h0, IRQ}, 32'h0);
        GPIO_DIN[0] = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        wr(8'h20, 32'h01);
        check("set_beats_clear_irq", {31'h0, IRQ}, 32'h1);
        rd(8'h1C, d); check("set_beats_clear_mis", d, 32'h1);

        // Both-edge interrupt on pin1
        wr(8'h14, 32'h00);
        wr(8'h24, 32'h02);
        wr(8'h2C, 32'h02);
        wr(8'h14, 32'h02);
        wr(8'h20, 32'hFF);
        check("ibe_idle", {31'h0, IRQ}, 32'h0);
        GPIO_DIN[1] = 1'b1;
        cycles(5);
        rd(8'h1C, d); check("ibe_rise", d, 32'h2);
        wr(8'h20, 32'h02);
        rd(8'h1C, d); check("ibe_cleared", d, 32'h0);
        GPIO_DIN[1] = 1'b0;
        cycles(5);
        rd(8'h1C, d); check("ibe_fall", d, 32'h2);
        wr(8'h20, 32'h02);

        // Level-low interrupt on pin2
        wr(8'h24, 32'h00);
        wr(8'h28, 32'h00);
        wr(8'h14, 32'h04);
        check("lvl_irq", {31'h0, IRQ}, 32'h1);
        wr(8'h20, 32'h04);
        check("lvl_icr_noeffect", {31'h0, IRQ}, 32'h1);
        GPIO_DIN[2] = 1'b1;
        cycles(1); check("lvl_edge1", {31'h0, IRQ}, 32'h1);
        cycles(1); check("lvl_edge2", {31'h0, IRQ}, 32'h1);
        cycles(1); check("lvl_edge3", {31'h0, IRQ}, 32'h0);

        // IS 1 -> 0 discards sticky status on pin3
        wr(8'h24, 32'h08);
        wr(8'h28, 32'h08);
        wr(8'h14, 32'h08);
        wr(8'h20, 32'hFF);
        GPIO_DIN[3] = 1'b1;
        cycles(5);
        rd(8'h18, d); check("sticky_set", d & 32'h08, 32'h08);
        GPIO_DIN[3] = 1'b0;
        cycles(5);
        rd(8'h18, d); check("sticky_held", d & 32'h08, 32'h08);
        wr(8'h24, 32'h00);
        rd(8'h18, d); check("is_to_level", d & 32'h08, 32'h00);
        check("is_to_level_irq", {31'h0, IRQ}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
